// File: rtl/fact_pkg.sv
// Shared constants and types for the factorial accelerator responder.
`timescale 1ns/1ps
package fact_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int N_W_DEF    = 4;
    localparam int MAX_N_DEF  = 12;

    localparam logic [1:0] OFF_N      = 2'd0;
    localparam logic [1:0] OFF_GO     = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_RESULT = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MULT = 2'd2
    } state_e;

    localparam int STAT_DONE = 0;
    localparam int STAT_ERR  = 1;
    localparam int STAT_BUSY = 2;
    localparam int STAT_IRQ  = 3;

endpackage

// File: rtl/fact_datapath.sv
// Iterative multiply datapath: product accumulates product*cnt while cnt counts down.
`timescale 1ns/1ps
module fact_datapath #(
    parameter int DATA_W = 32,
    parameter int N_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [N_W-1:0]    n_in,
    output logic [DATA_W-1:0] product,
    output logic              cnt_le1
);

    localparam logic [N_W-1:0]    CNT_ONE  = {{(N_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] PROD_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [N_W-1:0]    cnt_r;
    logic [DATA_W-1:0] product_r;

    // Counter and product registers; a load seeds product with 1 and cnt with n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= '0;
            product_r <= '0;
        end else if (load) begin
            cnt_r     <= n_in;
            product_r <= PROD_ONE;
        end else if (step) begin
            cnt_r     <= cnt_r - CNT_ONE;
            product_r <= product_r * {{(DATA_W-N_W){1'b0}}, cnt_r};
        end else begin
            cnt_r     <= cnt_r;
            product_r <= product_r;
        end
    end

    assign product = product_r;
    assign cnt_le1 = (cnt_r <= CNT_ONE);

endmodule

// File: rtl/fact_responder.sv
// Bus responder for the factorial accelerator window: register file, control FSM, datapath.
// Optional interrupt output and STATUS-write clear are enabled with `define FACT_IRQ_EN.
`timescale 1ns/1ps
module fact_responder
    import fact_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_W    = N_W_DEF,
    parameter int MAX_N  = MAX_N_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              WE,
    input  logic [1:0]        A,
    input  logic [DATA_W-1:0] WD,
    output logic [DATA_W-1:0] RD,
`ifdef FACT_IRQ_EN
    output logic              irq,
`endif
    output logic              busy
);

    localparam logic [N_W-1:0] MAX_N_L = N_W'(MAX_N);

    state_e            state_r;
    logic [N_W-1:0]    n_reg_r;
    logic [N_W-1:0]    n_lat_r;
    logic [DATA_W-1:0] result_r;
    logic              done_r;
    logic              err_r;
    logic              busy_r;

    logic [DATA_W-1:0] product_s;
    logic [DATA_W-1:0] status_s;
    logic              cnt_le1_s;
    logic              wr_n_s;
    logic              go_accept_s;
    logic              n_bad_s;
    logic              dp_load_s;
    logic              dp_step_s;
    logic              done_set_s;
    logic              unused_s;

    // Write decode and FSM-derived datapath controls.
    always_comb begin
        wr_n_s      = WE && (A == OFF_N);
        go_accept_s = WE && (A == OFF_GO) && WD[0] && (state_r == IDLE);
        n_bad_s     = (n_lat_r > MAX_N_L);
        dp_load_s   = (state_r == LOAD) && !n_bad_s;
        dp_step_s   = (state_r == MULT) && !cnt_le1_s;
        done_set_s  = ((state_r == LOAD) && n_bad_s) || ((state_r == MULT) && cnt_le1_s);
    end

    assign unused_s = ^WD[DATA_W-1:N_W];

    // N register is writable at any time; the running job works from n_lat_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg_r <= '0;
        end else if (wr_n_s) begin
            n_reg_r <= WD[N_W-1:0];
        end else begin
            n_reg_r <= n_reg_r;
        end
    end

    // Control FSM; GO is only honoured in IDLE so a busy job cannot be restarted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            n_lat_r  <= '0;
            result_r <= '0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (go_accept_s) begin
                        state_r <= LOAD;
                        n_lat_r <= n_reg_r;
                        done_r  <= 1'b0;
                        err_r   <= 1'b0;
                        busy_r  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (n_bad_s) begin
                        state_r  <= IDLE;
                        result_r <= '0;
                        err_r    <= 1'b1;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                    end else begin
                        state_r <= MULT;
                    end
                end
                MULT: begin
                    if (cnt_le1_s) begin
                        state_r  <= IDLE;
                        result_r <= product_s;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    fact_datapath #(
        .DATA_W (DATA_W),
        .N_W    (N_W)
    ) u_datapath (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (dp_load_s),
        .step    (dp_step_s),
        .n_in    (n_lat_r),
        .product (product_s),
        .cnt_le1 (cnt_le1_s)
    );

`ifdef FACT_IRQ_EN
    logic irq_r;
    logic irq_clr_s;

    assign irq_clr_s = (WE && (A == OFF_STATUS) && WD[0]) || go_accept_s;

    // Interrupt latches on completion; a clear in the same cycle takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_r <= 1'b0;
        end else if (irq_clr_s) begin
            irq_r <= 1'b0;
        end else if (done_set_s) begin
            irq_r <= 1'b1;
        end else begin
            irq_r <= irq_r;
        end
    end

    assign irq = irq_r;
`endif

    // STATUS word assembly.
    always_comb begin
        status_s            = '0;
        status_s[STAT_DONE] = done_r;
        status_s[STAT_ERR]  = err_r;
        status_s[STAT_BUSY] = busy_r;
`ifdef FACT_IRQ_EN
        status_s[STAT_IRQ]  = irq_r;
`endif
    end

    // Side-effect-free read mux.
    always_comb begin
        case (A)
            OFF_N:      RD = {{(DATA_W-N_W){1'b0}}, n_reg_r};
            OFF_GO:     RD = '0;
            OFF_STATUS: RD = status_s;
            OFF_RESULT: RD = result_r;
            default:    RD = '0;
        endcase
    end

    assign busy = busy_r;

endmodule

// File: tb/tb_fact_responder.sv
// Scoreboard bench for fact_responder: each GO pushes its expected completion, a monitor checks it.
`timescale 1ns/1ps
module tb_fact_responder;
    import fact_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        WE = 1'b0;
    logic [1:0]  a_stim = 2'd0;
    logic [1:0]  a_mon = 2'd0;
    logic        mon_sel = 1'b0;
    logic [1:0]  A;
    logic [31:0] WD = 32'h0;
    logic [31:0] RD;
    logic        busy;
`ifdef FACT_IRQ_EN
    logic        irq;
    localparam logic [31:0] IRQ_BIT = 32'h0000_0008;
`else
    localparam logic [31:0] IRQ_BIT = 32'h0000_0000;
`endif

    assign A = mon_sel ? a_mon : a_stim;

    always #5 clk = ~clk;

    fact_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .WE    (WE),
        .A     (A),
        .WD    (WD),
        .RD    (RD),
`ifdef FACT_IRQ_EN
        .irq   (irq),
`endif
        .busy  (busy)
    );

    typedef struct packed {
        logic [31:0] status;
        logic [31:0] result;
        logic [31:0] cycles;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Completion monitor: on every busy fall outside reset, pop and compare.
    logic        busy_prev = 1'b0;
    logic [31:0] busy_cycles = 32'd0;
    exp_t        e;
    always @(negedge clk) begin
        if (rst_n && busy_prev && !busy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: got busy fall, expected none");
            end else begin
                e = sb.pop_front();
                mon_sel = 1'b1;
                a_mon = OFF_STATUS;
                #1;
                check("done_status", RD, e.status);
                a_mon = OFF_RESULT;
                #1;
                check("done_result", RD, e.result);
                mon_sel = 1'b0;
                check("busy_cycles", busy_cycles, e.cycles);
            end
        end
        if (busy && rst_n) busy_cycles = busy_cycles + 32'd1;
        else busy_cycles = 32'd0;
        busy_prev = busy;
    end

    task automatic write(input logic [1:0] a, input logic [31:0] d);
        WE = 1'b1;
        a_stim = a;
        WD = d;
        @(posedge clk);
        #1;
        WE = 1'b0;
        WD = 32'h0;
    endtask

    task automatic read(input logic [1:0] a, input logic [31:0] exp, input string name);
        a_stim = a;
        #1;
        check(name, RD, exp);
    endtask

    task automatic go(input logic [31:0] st, input logic [31:0] res, input logic [31:0] cyc);
        exp_t x;
        x.status = st;
        x.result = res;
        x.cycles = cyc;
        sb.push_back(x);
        write(OFF_GO, 32'h1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((busy || sb.size() != 0) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (busy || sb.size() != 0) begin
            errors++;
            $display("FAIL idle_timeout: got busy=%0b pending=%0d, expected idle", busy, sb.size());
        end
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'h0);
        read(OFF_N, 32'h0, "reset_n");
        read(OFF_GO, 32'h0, "reset_go");
        read(OFF_STATUS, 32'h0, "reset_status");
        read(OFF_RESULT, 32'h0, "reset_result");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // GO with bit0 clear does nothing
        write(OFF_N, 32'd5);
        read(OFF_N, 32'd5, "n_readback");
        write(OFF_GO, 32'h2);
        check("go_bit0_clear", {31'b0, busy}, 32'h0);
        read(OFF_STATUS, 32'h0, "go_bit0_status");

        // 5! = 120, busy for 6 cycles
        go(32'h1 | IRQ_BIT, 32'd120, 32'd6);
        check("busy_after_go", {31'b0, busy}, 32'h1);
        read(OFF_STATUS, 32'h4, "status_busy");
        wait_idle(40);
        read(OFF_RESULT, 32'd120, "result_5");
`ifndef FACT_IRQ_EN
        write(OFF_STATUS, 32'hF);
        read(OFF_STATUS, 32'h1, "status_write_ignored");
`endif
        write(OFF_RESULT, 32'hDEAD_BEEF);
        read(OFF_RESULT, 32'd120, "result_write_ignored");

        // 0! and 1! both take 2 cycles
        write(OFF_N, 32'd0);
        go(32'h1 | IRQ_BIT, 32'd1, 32'd2);
        wait_idle(40);
        write(OFF_N, 32'd1);
        go(32'h1 | IRQ_BIT, 32'd1, 32'd2);
        wait_idle(40);

        // largest legal n, then first overflowing n
        write(OFF_N, 32'd12);
        go(32'h1 | IRQ_BIT, 32'h1C8C_FC00, 32'd13);
        wait_idle(40);
        write(OFF_N, 32'd13);
        go(32'h3 | IRQ_BIT, 32'h0, 32'd1);
        wait_idle(40);
        read(OFF_RESULT, 32'h0, "result_err");
        write(OFF_N, 32'hFFFF_FFFF);
        read(OFF_N, 32'hF, "n_truncated");
        go(32'h3 | IRQ_BIT, 32'h0, 32'd1);
        wait_idle(40);

        // GO while busy is ignored; N write lands but job uses latched n
        write(OFF_N, 32'd5);
        go(32'h1 | IRQ_BIT, 32'd120, 32'd6);
        write(OFF_N, 32'd7);
        write(OFF_GO, 32'h1);
        check("busy_during_ignored_go", {31'b0, busy}, 32'h1);
        wait_idle(40);
        read(OFF_N, 32'd7, "n_after_busy_write");
        read(OFF_RESULT, 32'd120, "result_kept_120");
        go(32'h1 | IRQ_BIT, 32'd5040, 32'd8);
        wait_idle(40);
        read(OFF_RESULT, 32'd5040, "result_7");

        // reset during MULT aborts
        write(OFF_N, 32'd10);
        write(OFF_GO, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'h0);
        read(OFF_STATUS, 32'h0, "abort_status");
        read(OFF_RESULT, 32'h0, "abort_result");
        read(OFF_N, 32'h0, "abort_n");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("post_abort_busy", {31'b0, busy}, 32'h0);
        read(OFF_STATUS, 32'h0, "post_abort_status");
        read(OFF_RESULT, 32'h0, "post_abort_result");

`ifdef FACT_IRQ_EN
        check("irq_reset", {31'b0, irq}, 32'h0);
        write(OFF_N, 32'd3);
        go(32'h9, 32'd6, 32'd4);
        wait_idle(40);
        check("irq_set", {31'b0, irq}, 32'h1);
        write(OFF_STATUS, 32'h1);
        check("irq_status_clear", {31'b0, irq}, 32'h0);
        read(OFF_STATUS, 32'h1, "status_after_clear");
        // STATUS clear on the completion edge beats the set
        go(32'h1, 32'd6, 32'd4);
        repeat (3) @(posedge clk);
        write(OFF_STATUS, 32'h1);
        wait_idle(40);
        check("irq_clear_wins", {31'b0, irq}, 32'h0);
        go(32'h9, 32'd6, 32'd4);
        wait_idle(40);
        check("irq_set_again", {31'b0, irq}, 32'h1);
        go(32'h9, 32'd6, 32'd4);
        check("irq_go_clear", {31'b0, irq}, 32'h0);
        wait_idle(40);
`endif

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
